// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: mode encodings, gradient-width helper and a 3x3 window type.
// Pure declarations; no latency or flow control of its own.
package sobel_pkg;

  localparam logic [1:0] MODE_MAG  = 2'd0;
  localparam logic [1:0] MODE_PACK = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;

  localparam int PIX_W_DEF = 8;

  // Row-major [row][col]; row 0 is the top of the window.
  typedef logic [PIX_W_DEF-1:0] window_t [3][3];

  // A 3x3 Sobel sum of unsigned pixels needs three extra bits, sign included.
  function automatic int gw(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-row pixel store with asynchronous read and a synchronous write, so a read and a write
// to the same address in one cycle return the old word. No flow control; the caller gates wr_en.
module sobel_line_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_gradient_stream.sv
// Streaming 3x3 Sobel over raster grey pixels; a result is registered 1 cycle after its triggering accept.
// Input busy is raised while a held result is blocked by the sink, so nothing is ever dropped.
module sobel_gradient_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8,
  localparam int GW = gw(PIX_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_mode,
  input  logic [GW-1:0]     i_thresh,
  input  logic              i_grey_vld,
  input  logic [PIX_W-1:0]  i_grey_data,
  output logic              i_grey_busy,
  input  logic              o_result_busy,
  output logic              o_result_vld,
  output logic [2*GW-1:0]   o_result_data,
  output logic              o_result_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic             accept, handoff, trig;
  logic             col_end, row_end;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] hist [3][2];
  logic [GW-1:0]    gx, gy, ax, ay, mag;
  logic [GW:0]      mag_raw;
  logic [2*GW-1:0]  res;

  assign i_grey_busy = i_rst && o_result_vld && o_result_busy;
  assign accept      = i_grey_vld && !i_grey_busy;
  assign handoff     = o_result_vld && !o_result_busy;
  assign col_end     = (col == CW'(IMG_W - 1));
  assign row_end     = (row == RW'(IMG_H - 1));
  assign trig        = accept && (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      col    <= '0;
      row    <= '0;
      mode_q <= MODE_MAG;
    end else if (accept) begin
      if (col == '0 && row == '0) mode_q <= i_mode;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // LB0 holds the previous row, LB1 the one before; LB1 is fed by LB0's old word.
  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (i_clk),
    .wr_en   (accept && i_rst),
    .addr    (col),
    .wr_data (i_grey_data),
    .rd_data (lb0_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (i_clk),
    .wr_en   (accept && i_rst),
    .addr    (col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Only the left and middle columns are stored; the right column is the live read/pixel.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      hist[0][0] <= hist[0][1];
      hist[1][0] <= hist[1][1];
      hist[2][0] <= hist[2][1];
      hist[0][1] <= lb1_rd;
      hist[1][1] <= lb0_rd;
      hist[2][1] <= i_grey_data;
    end
  end

  function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return {3'b000, p};
  endfunction

  assign gx = (ext(lb1_rd) + (ext(lb0_rd) << 1) + ext(i_grey_data))
            - (ext(hist[0][0]) + (ext(hist[1][0]) << 1) + ext(hist[2][0]));
  assign gy = (ext(hist[2][0]) + (ext(hist[2][1]) << 1) + ext(i_grey_data))
            - (ext(hist[0][0]) + (ext(hist[0][1]) << 1) + ext(lb1_rd));

  assign ax      = gx[GW-1] ? (~gx + 1'b1) : gx;
  assign ay      = gy[GW-1] ? (~gy + 1'b1) : gy;
  assign mag_raw = {1'b0, ax} + {1'b0, ay};
  assign mag     = mag_raw[GW] ? {GW{1'b1}} : mag_raw[GW-1:0];

  always_comb begin
    res = '0;
    case (mode_q)
      MODE_PACK: res = {gx, gy};
      MODE_THR:  res = {{GW{1'b0}}, (mag >= i_thresh) ? {GW{1'b1}} : {GW{1'b0}}};
      default:   res = {{GW{1'b0}}, mag};
    endcase
  end

  // A trigger only happens when the register is empty or being handed off this cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_result_vld  <= 1'b0;
      o_result_data <= '0;
      o_result_last <= 1'b0;
    end else if (trig) begin
      o_result_vld  <= 1'b1;
      o_result_data <= res;
      o_result_last <= row_end && col_end;
    end else if (handoff) begin
      o_result_vld  <= 1'b0;
    end
  end

endmodule
